// File: rtl/controle_bloqueio_pkg.sv
// Shared types and constants for the lock supervisor (controle_bloqueio).
// Holds the FSM state encoding, err_cnt width and escalation ceiling.
package controle_bloqueio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    OPENED = 2'd2
  } state_t;

  localparam int ERR_W     = 4;
  localparam int LEVEL_MAX = 3;

endpackage

// File: rtl/contador_regressivo.sv
// Loadable down-counter used as the lockout / open-time timer.
// Ports: clk, rst (sync, active-high), load, load_val, en -> zero flag.
module contador_regressivo #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/controle_bloqueio.sv
// Supervisor for the keyA/keyB lock FSM: counts failed attempts, imposes
// a timed lockout masking enter, and pulses relock when OPEN times out.
// Ports: clk_div, rst (sync, active-high), OPEN, ERROR, sinc_enter in;
// enter_ok, lockout, relock, err_cnt[3:0] out.
// Option: define LOCKOUT_ESCALATE_EN to double the lockout per repeat.
module controle_bloqueio
  import controle_bloqueio_pkg::*;
#(
  parameter int MAX_ERR     = 3,
  parameter int LOCK_CYCLES = 100,
  parameter int OPEN_CYCLES = 50,
  parameter int TMR_W       = 16
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             OPEN,
  input  logic             ERROR,
  input  logic             sinc_enter,
  output logic             enter_ok,
  output logic             lockout,
  output logic             relock,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state;
  logic             error_q;
  logic             open_q;
  logic             err_rise;
  logic             open_rise;
  logic             last_err;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic [TMR_W-1:0] duration;

  assign err_rise  = ERROR & ~error_q;
  assign open_rise = OPEN & ~open_q;
  assign enter_ok  = sinc_enter & ~lockout;

  // Compare in ERR_W+1 bits so err_cnt+1 cannot wrap.
  assign last_err =
    ({1'b0, err_cnt} + (ERR_W+1)'(1)) >= (ERR_W+1)'(MAX_ERR);

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] lock_level;
  assign duration = TMR_W'(LOCK_CYCLES) << lock_level;
`else
  assign duration = TMR_W'(LOCK_CYCLES);
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state == IDLE) begin
      if (open_rise) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(OPEN_CYCLES) - TMR_W'(1);
      end else if (err_rise && last_err) begin
        tmr_load = 1'b1;
        tmr_val  = duration - TMR_W'(1);
      end
    end
  end

  // LOCKED and OPENED never overlap, so one timer serves both.
  assign tmr_en = (state != IDLE);

  contador_regressivo #(
    .TMR_W(TMR_W)
  ) u_tmr (
    .clk     (clk_div),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk_div) begin
    if (rst) begin
      state   <= IDLE;
      error_q <= 1'b0;
      open_q  <= 1'b0;
      lockout <= 1'b0;
      relock  <= 1'b0;
      err_cnt <= '0;
`ifdef LOCKOUT_ESCALATE_EN
      lock_level <= 2'd0;
`endif
    end else begin
      error_q <= ERROR;
      open_q  <= OPEN;
      relock  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (open_rise) begin
            err_cnt <= '0;
            state   <= OPENED;
`ifdef LOCKOUT_ESCALATE_EN
            lock_level <= 2'd0;
`endif
          end else if (err_rise) begin
            if (last_err) begin
              err_cnt <= ERR_W'(MAX_ERR);
              lockout <= 1'b1;
              state   <= LOCKED;
            end else begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
          end
        end
        LOCKED: begin
          if (tmr_zero) begin
            err_cnt <= '0;
            lockout <= 1'b0;
            state   <= IDLE;
`ifdef LOCKOUT_ESCALATE_EN
            if (lock_level != 2'(LEVEL_MAX))
              lock_level <= lock_level + 2'd1;
`endif
          end
        end
        OPENED: begin
          // OPEN dropping wins over a simultaneous timeout.
          if (!OPEN) begin
            state <= IDLE;
          end else if (tmr_zero) begin
            relock <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          lockout <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
